// File: rtl/flag_cond_unit.sv
// ============================================================================
// Module   : flag_cond_unit
// Purpose  : Consumer end of the 64-bit ALU flag outputs. Captures NZCV from
//            flag-setting ALU ops into the architectural flags register and
//            resolves A64 B.cond condition queries over a valid/ready
//            handshake. A counter of in-flight flag writers makes sure a
//            query is never evaluated against stale flags.
// Ports    : clk          - clock, all state on the rising edge
//            reset_n      - asynchronous active-low reset
//            alu_negative - ALU N flag
//            alu_zero     - ALU Z flag
//            alu_carry    - ALU C flag
//            alu_overflow - ALU V flag
//            set_flags    - ALU flags valid; write flags, retire one writer
//            pend_issue   - flag-setting op issued (its set_flags comes later)
//            cond_valid   - condition query valid
//            cond_code    - A64 condition code of the query
//            cond_ready   - query accepted when cond_valid & cond_ready
//            take_valid   - resolution valid
//            take         - 1 = condition true (branch taken)
//            take_ready   - branch logic consumes the resolution
//            flags_q      - registered {N,Z,C,V}
//            pend_err     - sticky writer-counter over/underflow indication
// Config   : FLAG_FWD_EN  - when defined, a query waiting on the last
//            in-flight writer is evaluated on the incoming ALU flags in the
//            same cycle they arrive, saving one cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module flag_cond_unit #(
  parameter int unsigned PEND_W    = 2,
  parameter logic [3:0]  FLAGS_RST = 4'b0000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       alu_negative,
  input  logic       alu_zero,
  input  logic       alu_carry,
  input  logic       alu_overflow,
  input  logic       set_flags,
  input  logic       pend_issue,
  input  logic       cond_valid,
  input  logic [3:0] cond_code,
  output logic       cond_ready,
  output logic       take_valid,
  output logic       take,
  input  logic       take_ready,
  output logic [3:0] flags_q,
  output logic       pend_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [PEND_W-1:0] PEND_MAX  = {PEND_W{1'b1}};
  localparam logic [PEND_W-1:0] PEND_ZERO = '0;
  localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);

  state_t            state;
  logic [PEND_W-1:0] pend;
  logic [3:0]        code_q;
  logic [3:0]        alu_flags;
  logic              pend_zero;
  logic              fwd_hit;
  logic              accept;

  assign alu_flags  = {alu_negative, alu_zero, alu_carry, alu_overflow};
  assign pend_zero  = (pend == PEND_ZERO);
  assign cond_ready = (state == S_IDLE);
  assign accept     = cond_valid && cond_ready;

  // Forwarding is only safe when the incoming write is the very last
  // outstanding one; a same-cycle pend_issue means another writer follows.
`ifdef FLAG_FWD_EN
  assign fwd_hit = (pend == PEND_ONE) && set_flags && !pend_issue;
`else
  assign fwd_hit = 1'b0;
`endif

  // A64 condition evaluation over f = {N,Z,C,V}.
  function automatic logic cond_eval(input logic [3:0] code, input logic [3:0] f);
    logic n, z, c, v;
    logic res;
    n = f[3];
    z = f[2];
    c = f[1];
    v = f[0];
    case (code)
      4'h0:    res = z;
      4'h1:    res = !z;
      4'h2:    res = c;
      4'h3:    res = !c;
      4'h4:    res = n;
      4'h5:    res = !n;
      4'h6:    res = v;
      4'h7:    res = !v;
      4'h8:    res = c && !z;
      4'h9:    res = !c || z;
      4'hA:    res = (n == v);
      4'hB:    res = (n != v);
      4'hC:    res = !z && (n == v);
      4'hD:    res = z || (n != v);
      default: res = 1'b1;  // AL and NV are both unconditional
    endcase
    return res;
  endfunction

  // --------------------------------------------------------------------------
  // Architectural flags register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flags_q <= FLAGS_RST;
    end else if (set_flags) begin
      flags_q <= alu_flags;
    end
  end

  // --------------------------------------------------------------------------
  // In-flight flag-writer counter with sticky error on over/underflow.
  // Simultaneous issue and retire cancel out, even at the limits.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend     <= PEND_ZERO;
      pend_err <= 1'b0;
    end else begin
      if (pend_issue && !set_flags) begin
        if (pend == PEND_MAX) begin
          pend_err <= 1'b1;
        end else begin
          pend <= pend + PEND_ONE;
        end
      end else if (set_flags && !pend_issue) begin
        if (pend_zero) begin
          pend_err <= 1'b1;
        end else begin
          pend <= pend - PEND_ONE;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Query FSM with registered resolution outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      code_q     <= 4'h0;
      take_valid <= 1'b0;
      take       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            code_q <= cond_code;
            // AL/NV never depend on flags, so they need not wait.
            if ((cond_code[3:1] == 3'b111) || pend_zero) begin
              take       <= cond_eval(cond_code, flags_q);
              take_valid <= 1'b1;
              state      <= S_DONE;
            end else if (fwd_hit) begin
              take       <= cond_eval(cond_code, alu_flags);
              take_valid <= 1'b1;
              state      <= S_DONE;
            end else begin
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          // pend is registered, so pend==0 implies flags_q already holds the
          // last writer's result.
          if (pend_zero) begin
            take       <= cond_eval(code_q, flags_q);
            take_valid <= 1'b1;
            state      <= S_DONE;
          end else if (fwd_hit) begin
            take       <= cond_eval(code_q, alu_flags);
            take_valid <= 1'b1;
            state      <= S_DONE;
          end
        end
        S_DONE: begin
          if (take_ready) begin
            take_valid <= 1'b0;
            state      <= S_IDLE;
          end
        end
        default: begin
          take_valid <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_flag_cond_unit.sv
// ============================================================================
// Module   : tb_flag_cond_unit
// Purpose  : Directed self-checking bench for flag_cond_unit. Expected values
//            are hand-derived from the A64 condition table.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_flag_cond_unit;

  logic       clk;
  logic       reset_n;
  logic       alu_negative, alu_zero, alu_carry, alu_overflow;
  logic       set_flags;
  logic       pend_issue;
  logic       cond_valid;
  logic [3:0] cond_code;
  logic       cond_ready;
  logic       take_valid;
  logic       take;
  logic       take_ready;
  logic [3:0] flags_q;
  logic       pend_err;

  int checks = 0;
  int errors = 0;

  flag_cond_unit #(
    .PEND_W   (2),
    .FLAGS_RST(4'b0000)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .alu_negative(alu_negative),
    .alu_zero    (alu_zero),
    .alu_carry   (alu_carry),
    .alu_overflow(alu_overflow),
    .set_flags   (set_flags),
    .pend_issue  (pend_issue),
    .cond_valid  (cond_valid),
    .cond_code   (cond_code),
    .cond_ready  (cond_ready),
    .take_valid  (take_valid),
    .take        (take),
    .take_ready  (take_ready),
    .flags_q     (flags_q),
    .pend_err    (pend_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled and inputs changed 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_alu(input logic [3:0] f);
    {alu_negative, alu_zero, alu_carry, alu_overflow} = f;
  endtask

  // Properly paired writer: issue, then its set_flags one cycle later.
  task automatic write_flags(input logic [3:0] f);
    pend_issue = 1'b1;
    step();
    pend_issue = 1'b0;
    drive_alu(f);
    set_flags = 1'b1;
    step();
    set_flags = 1'b0;
    check("flags_write", {28'd0, flags_q}, {28'd0, f});
  endtask

  // Query at pend==0: resolution must be visible right after the accept edge.
  task automatic query(input string tag, input logic [3:0] code, input logic exp_take);
    cond_valid = 1'b1;
    cond_code  = code;
    step();
    cond_valid = 1'b0;
    check({tag, "_valid"}, {31'd0, take_valid}, 32'd1);
    check({tag, "_take"},  {31'd0, take}, {31'd0, exp_take});
    take_ready = 1'b1;
    step();
    take_ready = 1'b0;
    check({tag, "_drop"}, {31'd0, take_valid}, 32'd0);
  endtask

  // Bounded wait for a resolution; expiry is reported as a failed check.
  task automatic wait_take(input string tag, input logic exp_take);
    int n;
    n = 0;
    while (!take_valid && n < 4) begin
      step();
      n++;
    end
    check({tag, "_valid"}, {31'd0, take_valid}, 32'd1);
    check({tag, "_take"},  {31'd0, take}, {31'd0, exp_take});
    take_ready = 1'b1;
    step();
    take_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    step();
  endtask

  // Expected take per code (bit i = code i) for three flag patterns {N,Z,C,V}.
  logic [3:0]  pat_flags [3];
  logic [15:0] pat_take  [3];
  logic [15:0] row;

  initial begin
    pat_flags[0] = 4'b1010; pat_take[0] = 16'hE996;
    pat_flags[1] = 4'b0101; pat_take[1] = 16'hEA69;
    pat_flags[2] = 4'b0010; pat_take[2] = 16'hD5A6;

    reset_n    = 1'b0;
    drive_alu(4'b0000);
    set_flags  = 1'b0;
    pend_issue = 1'b0;
    cond_valid = 1'b0;
    cond_code  = 4'h0;
    take_ready = 1'b0;

    // Reset state
    step();
    check("rst_flags", {28'd0, flags_q}, 32'd0);
    check("rst_take_valid", {31'd0, take_valid}, 32'd0);
    check("rst_take", {31'd0, take}, 32'd0);
    check("rst_pend_err", {31'd0, pend_err}, 32'd0);
    reset_n = 1'b1;
    step();
    check("rst_cond_ready", {31'd0, cond_ready}, 32'd1);

    // Z=1 then EQ / NE
    write_flags(4'b0100);
    query("eq_z1", 4'h0, 1'b1);
    query("ne_z1", 4'h1, 1'b0);

    // GT waits on an in-flight writer
    pend_issue = 1'b1;
    step();
    pend_issue = 1'b0;
    cond_valid = 1'b1;
    cond_code  = 4'hC;
    step();
    cond_valid = 1'b0;
    check("gt_wait_valid", {31'd0, take_valid}, 32'd0);
    check("gt_wait_ready", {31'd0, cond_ready}, 32'd0);
    drive_alu(4'b1001);
    set_flags = 1'b1;
    step();
    set_flags = 1'b0;
`ifdef FLAG_FWD_EN
    check("gt_fwd_valid", {31'd0, take_valid}, 32'd1);
`else
    check("gt_nofwd_valid", {31'd0, take_valid}, 32'd0);
    step();
    check("gt_nofwd_valid2", {31'd0, take_valid}, 32'd1);
`endif
    check("gt_take", {31'd0, take}, 32'd1);
    check("gt_flags", {28'd0, flags_q}, 32'h9);
    // Held resolution stays stable without take_ready
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold_valid", {31'd0, take_valid}, 32'd1);
      check("hold_take", {31'd0, take}, 32'd1);
      check("hold_ready", {31'd0, cond_ready}, 32'd0);
    end
    take_ready = 1'b1;
    step();
    take_ready = 1'b0;
    check("gt_release", {31'd0, cond_ready}, 32'd1);

    // pend=2: AL resolves immediately, EQ waits, then reset mid-WAIT
    pend_issue = 1'b1;
    step();
    step();
    pend_issue = 1'b0;
    query("al_pend2", 4'hE, 1'b1);
    cond_valid = 1'b1;
    cond_code  = 4'h0;
    step();
    cond_valid = 1'b0;
    check("eq_pend2_wait", {31'd0, take_valid}, 32'd0);
    step();
    check("eq_pend2_wait2", {31'd0, take_valid}, 32'd0);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_flags", {28'd0, flags_q}, 32'd0);
    check("async_rst_valid", {31'd0, take_valid}, 32'd0);
    step();
    reset_n = 1'b1;
    step();
    check("post_rst_ready", {31'd0, cond_ready}, 32'd1);
    check("post_rst_valid", {31'd0, take_valid}, 32'd0);
    check("post_rst_err", {31'd0, pend_err}, 32'd0);
    // pend cleared by reset: EQ resolves at once on flags 0000
    query("eq_post_rst", 4'h0, 1'b0);

    // Issue and retire in the same cycle at pend=1
    pend_issue = 1'b1;
    step();
    drive_alu(4'b1010);
    set_flags = 1'b1;
    step();
    pend_issue = 1'b0;
    set_flags  = 1'b0;
    check("same_cyc_flags", {28'd0, flags_q}, 32'hA);
    cond_valid = 1'b1;
    cond_code  = 4'h2;
    step();
    cond_valid = 1'b0;
    check("same_cyc_wait", {31'd0, take_valid}, 32'd0);
    drive_alu(4'b1000);
    set_flags = 1'b1;
    step();
    set_flags = 1'b0;
    wait_take("same_cyc_cs", 1'b0);
    check("same_cyc_err", {31'd0, pend_err}, 32'd0);

    // Full condition table over three flag patterns
    for (int p = 0; p < 3; p++) begin
      write_flags(pat_flags[p]);
      row = pat_take[p];
      for (int c = 0; c < 16; c++) begin
        query($sformatf("cond_p%0d_c%0h", p, c), 4'(c), row[c]);
      end
    end
    check("table_err", {31'd0, pend_err}, 32'd0);

    // Counter saturation at 3 with sticky error
    do_reset();
    pend_issue = 1'b1;
    step();
    step();
    step();
    check("ovf_err_pre", {31'd0, pend_err}, 32'd0);
    step();
    pend_issue = 1'b0;
    check("ovf_err", {31'd0, pend_err}, 32'd1);
    drive_alu(4'b0000);
    set_flags = 1'b1;
    step();
    step();
    set_flags = 1'b0;
    cond_valid = 1'b1;
    cond_code  = 4'h0;
    step();
    cond_valid = 1'b0;
    check("sat_wait", {31'd0, take_valid}, 32'd0);
    drive_alu(4'b0100);
    set_flags = 1'b1;
    step();
    set_flags = 1'b0;
    wait_take("sat_eq", 1'b1);
    check("ovf_err_sticky", {31'd0, pend_err}, 32'd1);

    // Underflow: set_flags at pend=0 still writes flags
    do_reset();
    drive_alu(4'b1100);
    set_flags = 1'b1;
    step();
    set_flags = 1'b0;
    check("udf_err", {31'd0, pend_err}, 32'd1);
    check("udf_flags", {28'd0, flags_q}, 32'hC);
    query("udf_mi", 4'h4, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time guard
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
